// File: rtl/ysyx_lsu_sram_resp.sv
// ysyx_lsu_sram_resp
//   Slave-side responder for the LSU store (aw/w) and load (ar) channels,
//   backed by a word-organised on-chip SRAM window at BASE_ADDR.
//   Each transaction is acknowledged with a single-cycle pulse (wready or
//   rvalid) after WR_LAT / RD_LAT extra wait cycles. Every ack is followed
//   by one IDLE cycle.
//
// Ports
//   clock, reset          clock and synchronous active-high reset
//   awvalid/awaddr        store address (held with wvalid until wready)
//   wvalid/wdata/wstrb    store data and LSB-aligned byte mask
//   wready                1-cycle pulse: store committed
//   arvalid/araddr        load request (held until rvalid)
//   rvalid/rdata          1-cycle pulse with the full aligned word
//   err                   out-of-window flag, valid with wready/rvalid
//
// Configuration
//   YSYX_LSU_SRAM_RESP_ERR_EN  defined: out-of-window accesses are flagged,
//                              writes dropped, reads return 0.
//                              undefined: err is 0 and the word index
//                              aliases modulo MEM_WORDS.
//
// state   | meaning
// IDLE    | waiting for a request; writes win over reads
// WR_WAIT | counting down WR_LAT, SRAM written when cnt reaches 0
// WR_ACK  | wready pulse
// RD_WAIT | counting down RD_LAT, word captured when cnt reaches 0
// RD_ACK  | rvalid pulse, rdata valid

module ysyx_lsu_sram_resp #(
    parameter int                XLEN      = 32,
    parameter int                MEM_WORDS = 2048,
    parameter logic [XLEN-1:0]   BASE_ADDR = 32'h0f000000,
    parameter int                WR_LAT    = 1,
    parameter int                RD_LAT    = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            awvalid,
    input  logic [XLEN-1:0] awaddr,
    input  logic            wvalid,
    input  logic [XLEN-1:0] wdata,
    input  logic [3:0]      wstrb,
    output logic            wready,
    input  logic            arvalid,
    input  logic [XLEN-1:0] araddr,
    output logic            rvalid,
    output logic [XLEN-1:0] rdata,
    output logic            err
);

`ifdef YSYX_LSU_SRAM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int         IW     = $clog2(MEM_WORDS);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT);
    localparam logic [3:0] RD_CNT = 4'(RD_LAT);

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_ACK,
        RD_WAIT,
        RD_ACK
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] data_q;
    logic [3:0]      strb_q;

    logic [XLEN-1:0] mem [MEM_WORDS];

    logic [XLEN-1:0] word_idx;
    logic [IW-1:0]   mem_idx;
    logic            in_window;
    logic            oob;
    logic [3:0]      lane_en;
    logic [XLEN-1:0] data_sh;
    logic            mem_we;

    // Full-width subtraction so addresses below BASE_ADDR wrap to a huge
    // index and fall out of the window.
    assign word_idx  = (addr_q - BASE_ADDR) >> 2;
    assign in_window = word_idx < XLEN'(MEM_WORDS);
    assign mem_idx   = IW'(word_idx % XLEN'(MEM_WORDS));
    assign oob       = ERR_EN && !in_window;

    // 4-bit shift drops lanes pushed past byte 3: no word crossing.
    assign lane_en = strb_q << addr_q[1:0];
    assign data_sh = data_q << {addr_q[1:0], 3'b000};
    assign mem_we  = (state == WR_WAIT) && (cnt == 4'd0) && !oob;

    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[mem_idx][8*i +: 8] <= data_sh[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr_q <= '0;
            data_q <= '0;
            strb_q <= 4'd0;
            wready <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            wready <= 1'b0;
            rvalid <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (awvalid && wvalid) begin
                        addr_q <= awaddr;
                        data_q <= wdata;
                        strb_q <= wstrb;
                        cnt    <= WR_CNT;
                        state  <= WR_WAIT;
                    end else if (arvalid) begin
                        addr_q <= araddr;
                        cnt    <= RD_CNT;
                        state  <= RD_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        wready <= 1'b1;
                        err    <= oob;
                        state  <= WR_ACK;
                    end
                end
                WR_ACK: state <= IDLE;
                RD_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rvalid <= 1'b1;
                        err    <= oob;
                        rdata  <= oob ? '0 : mem[mem_idx];
                        state  <= RD_ACK;
                    end
                end
                RD_ACK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_lsu_sram_resp.sv
module tb_ysyx_lsu_sram_resp;

    logic        clock = 1'b0;
    logic        reset, reset4;
    logic        awvalid, wvalid, arvalid;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        wready, rvalid, err;
    logic [31:0] rdata;
    logic        wready4, rvalid4, err4;
    logic [31:0] rdata4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ysyx_lsu_sram_resp u_dut (
        .clock(clock), .reset(reset),
        .awvalid(awvalid), .awaddr(awaddr), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb),
        .wready(wready), .arvalid(arvalid), .araddr(araddr),
        .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    // Long write latency instance, only released from reset for the
    // mid-transaction reset scenario.
    ysyx_lsu_sram_resp #(.WR_LAT(4)) u_dut4 (
        .clock(clock), .reset(reset4),
        .awvalid(awvalid), .awaddr(awaddr), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb),
        .wready(wready4), .arvalid(arvalid), .araddr(araddr),
        .rvalid(rvalid4), .rdata(rdata4), .err(err4)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called with the responder in IDLE; returns with it back in IDLE.
    task automatic do_wr(input bit sel, input string tag, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic exp_err);
        int   n;
        logic ack, e;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0; ack = 1'b0;
        for (int i = 0; i < 40 && !ack; i++) begin
            step();
            n++;
            ack = sel ? wready4 : wready;
        end
        e = sel ? err4 : err;
        awvalid = 1'b0; wvalid = 1'b0;
        chk({tag, "_ack"}, 32'(ack), 32'd1);
        chk({tag, "_lat"}, 32'(n), sel ? 32'd6 : 32'd3);
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
        step();
        chk({tag, "_pulse"}, 32'(sel ? wready4 : wready), 32'd0);
    endtask

    task automatic do_rd(input bit sel, input string tag, input logic [31:0] a,
                         input logic [31:0] exp_data, input logic exp_err);
        int          n;
        logic        ack, e;
        logic [31:0] d;
        araddr = a; arvalid = 1'b1;
        n = 0; ack = 1'b0;
        for (int i = 0; i < 40 && !ack; i++) begin
            step();
            n++;
            ack = sel ? rvalid4 : rvalid;
        end
        e = sel ? err4 : err;
        d = sel ? rdata4 : rdata;
        arvalid = 1'b0;
        chk({tag, "_ack"}, 32'(ack), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'd3);
        chk({tag, "_data"}, d, exp_data);
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
        step();
        chk({tag, "_pulse"}, 32'(sel ? rvalid4 : rvalid), 32'd0);
    endtask

    initial begin
        int   n;
        logic ack;
        reset = 1'b1; reset4 = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // word store / load
        do_wr(0, "sw0", 32'h0f000000, 32'hdeadbeef, 4'hf, 1'b0);
        do_rd(0, "lw0", 32'h0f000000, 32'hdeadbeef, 1'b0);

        // byte and halfword stores
        do_wr(0, "sw4", 32'h0f000004, 32'h11223344, 4'hf, 1'b0);
        do_wr(0, "sb5", 32'h0f000005, 32'h000000ab, 4'h1, 1'b0);
        do_rd(0, "lw4a", 32'h0f000004, 32'h1122ab44, 1'b0);
        do_wr(0, "sh6", 32'h0f000006, 32'h0000beef, 4'h3, 1'b0);
        do_rd(0, "lw4b", 32'h0f000004, 32'hbeefab44, 1'b0);
        do_wr(0, "sh7", 32'h0f000007, 32'h00001234, 4'h3, 1'b0);
        do_rd(0, "lw7", 32'h0f000006, 32'h34efab44, 1'b0);

        // simultaneous store and load to the same address
        awaddr = 32'h0f000008; wdata = 32'hcafef00d; wstrb = 4'hf; araddr = 32'h0f000008;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        n = 0; ack = 1'b0;
        for (int i = 0; i < 40 && !ack; i++) begin
            step(); n++; ack = wready;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("both_wr_ack", 32'(ack), 32'd1);
        chk("both_wr_lat", 32'(n), 32'd3);
        chk("both_rv_early", 32'(rvalid), 32'd0);
        n = 0; ack = 1'b0;
        for (int i = 0; i < 40 && !ack; i++) begin
            step(); n++; ack = rvalid;
        end
        arvalid = 1'b0;
        chk("both_rd_ack", 32'(ack), 32'd1);
        chk("both_rd_lat", 32'(n), 32'd4);
        chk("both_rd_data", rdata, 32'hcafef00d);
        step();

        // out-of-window access
`ifdef YSYX_LSU_SRAM_RESP_ERR_EN
        do_rd(0, "oob_rd", 32'h0f002000, 32'h00000000, 1'b1);
        do_wr(0, "oob_wr", 32'h0f002000, 32'h13579bdf, 4'hf, 1'b1);
        do_rd(0, "oob_chk", 32'h0f000000, 32'hdeadbeef, 1'b0);
`else
        do_rd(0, "alias_rd", 32'h0f002000, 32'hdeadbeef, 1'b0);
        do_wr(0, "alias_wr", 32'h0f002000, 32'h13579bdf, 4'hf, 1'b0);
        do_rd(0, "alias_chk", 32'h0f000000, 32'h13579bdf, 1'b0);
`endif

        // reset during WR_WAIT on the WR_LAT=4 instance
        reset4 = 1'b0;
        step();
        do_wr(1, "l4_sw", 32'h0f000010, 32'h11111111, 4'hf, 1'b0);
        do_rd(1, "l4_lw", 32'h0f000010, 32'h11111111, 1'b0);
        awaddr = 32'h0f000010; wdata = 32'h22222222; wstrb = 4'hf;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        step();
        reset4 = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
        step();
        chk("mid_rst_wready", 32'(wready4), 32'd0);
        chk("mid_rst_rvalid", 32'(rvalid4), 32'd0);
        chk("mid_rst_rdata", rdata4, 32'd0);
        chk("mid_rst_err", 32'(err4), 32'd0);
        reset4 = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (wready4) n++;
        end
        chk("mid_rst_no_ack", 32'(n), 32'd0);
        do_rd(1, "mid_rst_mem", 32'h0f000010, 32'h11111111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
